sr04_scan_scheduler: RTL

SR04_SCAN_SCHEDULER -- requirements
Module: sr04_scan_scheduler

---
 rtl/sr04_scan_scheduler_if.sv | 31 +++
 rtl/sr04_scan_scheduler.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/sr04_scan_scheduler_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : sr04_scan_scheduler_if
//  Description : Bus bundle between the SR04 scan scheduler and its host.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sr04_scan_scheduler_if;
    logic       tick_1us;
    logic       btn_r;
    logic       auto_en;
    logic [3:0] sens_en;
    logic [3:0] echo;
    logic [3:0] trigger;
    logic       busy;
    logic       dist_valid;
    logic [1:0] dist_id;
    logic [8:0] dist_cm;
    logic       timeout;

    modport master (
        output tick_1us, btn_r, auto_en, sens_en, echo,
        input  trigger, busy, dist_valid, dist_id, dist_cm, timeout
    );

    modport slave (
        input  tick_1us, btn_r, auto_en, sens_en, echo,
        output trigger, busy, dist_valid, dist_id, dist_cm, timeout
    );
endinterface
`default_nettype wire

// File: rtl/sr04_scan_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : sr04_scan_scheduler
//  Description : Round-robin trigger/echo scheduler for up to four HC-SR04s.
//  Revision    : 1.0 - initial release
// ============================================================================
module sr04_scan_scheduler #(
    parameter int TRIG_US    = 10,
    parameter int TIMEOUT_US = 30000,
    parameter int PERIOD_US  = 60000
) (
    input  logic                 clk,
    input  logic                 reset,
    sr04_scan_scheduler_if.slave bus
);
    localparam int CNT_MAX = (TIMEOUT_US > TRIG_US) ? TIMEOUT_US : TRIG_US;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int PW      = $clog2(PERIOD_US + 1);

    localparam logic [CW-1:0] c_trig_last = CW'(TRIG_US - 1);
    localparam logic [CW-1:0] c_tmo_last  = CW'(TIMEOUT_US - 1);
    localparam logic [PW-1:0] c_period    = PW'(PERIOD_US);
    localparam logic [8:0]    c_cm_max    = 9'd400;
    localparam logic [5:0]    c_pre_last  = 6'd57;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TRIG      = 3'd1,
        WAIT_ECHO = 3'd2,
        MEASURE   = 3'd3,
        DONE      = 3'd4,
        HOLDOFF   = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic          pending_q, pending_d;
    logic [1:0]    last_id_q, last_id_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [5:0]    pre_q, pre_d;
    logic [8:0]    cm_q, cm_d;
    logic [PW-1:0] period_q, period_d;
    logic [3:0]    trigger_q, trigger_d;
    logic          busy_q, busy_d;
    logic          dist_valid_q, dist_valid_d;
    logic [1:0]    dist_id_q, dist_id_d;
    logic [8:0]    dist_cm_q, dist_cm_d;
    logic          timeout_q, timeout_d;

    logic [1:0]    w_sel_id;
    logic [1:0]    w_probe;
    logic          w_echo_sel;

    // Walk downward so the nearest enabled index above last_id wins.
    always_comb begin
        w_sel_id = last_id_q;
        w_probe  = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            w_probe = last_id_q + 2'(k);
            if (bus.sens_en[w_probe]) w_sel_id = w_probe;
        end
    end

    assign w_echo_sel = bus.echo[last_id_q];

    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        last_id_d    = last_id_q;
        cnt_d        = cnt_q;
        pre_d        = pre_q;
        cm_d         = cm_q;
        period_d     = period_q;
        dist_valid_d = 1'b0;
        dist_id_d    = dist_id_q;
        dist_cm_d    = dist_cm_q;
        timeout_d    = timeout_q;

        if (bus.auto_en)    pending_d = 1'b0;
        else if (bus.btn_r) pending_d = 1'b1;

        // Period runs from trigger start and saturates so HOLDOFF can compare.
        if (state_q != IDLE && bus.tick_1us && period_q != c_period)
            period_d = period_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (bus.sens_en == 4'd0) begin
                    pending_d = 1'b0;
                end else if (bus.auto_en || pending_q) begin
                    state_d   = TRIG;
                    pending_d = 1'b0;
                    last_id_d = w_sel_id;
                    cnt_d     = '0;
                    period_d  = '0;
                end
            end
            TRIG: begin
                if (bus.tick_1us) begin
                    if (cnt_q == c_trig_last) begin
                        state_d = WAIT_ECHO;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            WAIT_ECHO: begin
                if (w_echo_sel) begin
                    state_d = MEASURE;
                    cnt_d   = '0;
                    pre_d   = '0;
                    cm_d    = '0;
                end else if (bus.tick_1us) begin
                    if (cnt_q == c_tmo_last) begin
                        state_d      = DONE;
                        dist_valid_d = 1'b1;
                        dist_id_d    = last_id_q;
                        dist_cm_d    = 9'd0;
                        timeout_d    = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            MEASURE: begin
                if (!w_echo_sel) begin
                    state_d      = DONE;
                    dist_valid_d = 1'b1;
                    dist_id_d    = last_id_q;
                    dist_cm_d    = cm_q;
                    timeout_d    = 1'b0;
                end else if (bus.tick_1us) begin
                    if (cnt_q == c_tmo_last) begin
                        state_d      = DONE;
                        dist_valid_d = 1'b1;
                        dist_id_d    = last_id_q;
                        dist_cm_d    = c_cm_max;
                        timeout_d    = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        if (pre_q == c_pre_last) begin
                            pre_d = '0;
                            if (cm_q != c_cm_max) cm_d = cm_q + 9'd1;
                        end else begin
                            pre_d = pre_q + 6'd1;
                        end
                    end
                end
            end
            DONE: begin
                state_d = HOLDOFF;
            end
            HOLDOFF: begin
                if (period_q >= c_period) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        trigger_d = (state_d == TRIG) ? (4'b0001 << last_id_d) : 4'b0000;
        busy_d    = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            pending_q    <= 1'b0;
            last_id_q    <= 2'd3;
            cnt_q        <= '0;
            pre_q        <= '0;
            cm_q         <= '0;
            period_q     <= '0;
            trigger_q    <= 4'd0;
            busy_q       <= 1'b0;
            dist_valid_q <= 1'b0;
            dist_id_q    <= 2'd0;
            dist_cm_q    <= 9'd0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            last_id_q    <= last_id_d;
            cnt_q        <= cnt_d;
            pre_q        <= pre_d;
            cm_q         <= cm_d;
            period_q     <= period_d;
            trigger_q    <= trigger_d;
            busy_q       <= busy_d;
            dist_valid_q <= dist_valid_d;
            dist_id_q    <= dist_id_d;
            dist_cm_q    <= dist_cm_d;
            timeout_q    <= timeout_d;
        end
    end

    assign bus.trigger    = trigger_q;
    assign bus.busy       = busy_q;
    assign bus.dist_valid = dist_valid_q;
    assign bus.dist_id    = dist_id_q;
    assign bus.dist_cm    = dist_cm_q;
    assign bus.timeout    = timeout_q;
endmodule
`default_nettype wire
